// File: rtl/rst_sync.sv
// rst_sync: reset synchronizer/stretcher for one clock domain.
//
// Turns the system reset input into a clean, registered active-low reset.
// Assertion takes effect on the first rising edge that samples RST low.
// Deassertion is delayed by a NUM_STAGES-deep flop chain, so downstream
// logic leaves reset on a clock edge with metastability margin.
//
// Parameters:
//   NUM_STAGES  depth of the synchronizer chain (>= 1)
//
// Ports:
//   CLK       in   clock; all state updates on the rising edge
//   RST       in   reset, synchronous, active-low
//   RST_SYNC  out  synchronized reset, active-low, driven directly by a flop
module rst_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic RST_SYNC
);

    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("rst_sync: NUM_STAGES must be >= 1");
    end

    logic [NUM_STAGES-1:0] sync_q;
    logic [NUM_STAGES-1:0] sync_d;

    // Shift a 1 in at stage 0. The loop form also covers NUM_STAGES == 1,
    // where a {sync_q[NUM_STAGES-2:0], 1'b1} slice would be out of range.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = 1'b1;
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // A low sample clears the whole chain, so every reset pulse restarts
    // the full deassertion count.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign RST_SYNC = sync_q[NUM_STAGES-1];

endmodule

// File: tb/tb_rst_sync.sv
// tb_rst_sync: self-checking bench for rst_sync.
//
// Four instances (NUM_STAGES = 3, 1, 2, 5) share one clock and reset input.
// The reference model for each instance tracks how many consecutive rising
// edges have sampled RST high: the synchronized reset must be high exactly
// when that run length has reached NUM_STAGES.
module tb_rst_sync;

    localparam int NDUT = 4;
    localparam int NS [NDUT] = '{3, 1, 2, 5};

    logic CLK;
    logic RST;
    logic rs3, rs1, rs2, rs5;
    logic [NDUT-1:0] obs;

    int checks;
    int errors;

    int hi_run   [NDUT];
    bit seen_low [NDUT];

    rst_sync #(.NUM_STAGES(3)) u_dut3 (.CLK(CLK), .RST(RST), .RST_SYNC(rs3));
    rst_sync #(.NUM_STAGES(1)) u_dut1 (.CLK(CLK), .RST(RST), .RST_SYNC(rs1));
    rst_sync #(.NUM_STAGES(2)) u_dut2 (.CLK(CLK), .RST(RST), .RST_SYNC(rs2));
    rst_sync #(.NUM_STAGES(5)) u_dut5 (.CLK(CLK), .RST(RST), .RST_SYNC(rs5));

    assign obs = {rs5, rs2, rs1, rs3};

    // First rising edge at t=5, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b expected %b", tag, $time, observed, expected);
        end
    endtask

    // Compare every instance against the model. Before the first low sample an
    // instance only has a defined output once its chain has filled with ones.
    task automatic check_all(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            if (seen_low[d] || hi_run[d] >= NS[d]) begin
                check_bit($sformatf("%s/N%0d", tag, NS[d]), obs[d], (hi_run[d] >= NS[d]) ? 1'b1 : 1'b0);
            end
        end
    endtask

    // One clock period: present lvl to the next rising edge, update the model
    // with the sampled value, check. With glitch set (and lvl high) a short low
    // pulse is placed strictly between edges; it must leave the outputs alone.
    task automatic cycle(input bit lvl, input bit glitch);
        RST = lvl;
        @(posedge CLK);
        for (int d = 0; d < NDUT; d++) begin
            if (RST) begin
                hi_run[d]++;
            end else begin
                hi_run[d]   = 0;
                seen_low[d] = 1'b1;
            end
        end
        #1;
        check_all("edge");
        if (glitch && lvl) begin
            #1 RST = 1'b0;
            #4 RST = 1'b1;
            #1;
            check_all("glitch");
        end else begin
            #6;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int d = 0; d < NDUT; d++) begin
            hi_run[d]   = 0;
            seen_low[d] = 1'b0;
        end
        RST = 1'b1;

        // Power-up with reset high from time 0.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        check_bit("powerup_n3_high", rs3, 1'b1);

        // Single low edge, then refill.
        cycle(1'b0, 1'b0);
        check_bit("single_low_n3", rs3, 1'b0);
        check_bit("single_low_n1", rs1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

        // Low for three edges.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

        // Re-assert during refill.
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check_bit("reassert_n3", rs3, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);

        // Inter-edge glitches while fully deasserted and while refilling.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
        check_bit("glitch_ignored_n5", rs5, 1'b1);

        // Randomized phase: bursts of high/low levels with occasional glitches.
        for (int i = 0; i < 400; i++) begin
            bit lvl;
            bit gl;
            lvl = ($urandom_range(0, 4) != 0);
            gl  = ($urandom_range(0, 5) == 0);
            cycle(lvl, gl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
